// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide, one bit per cycle; divide path present only with MULDIV_DIV_EN
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] f3;
    logic [XLEN-1:0] b;
    logic [2*XLEN-1:0] prod, prod_nx, p_fix;
    logic [CW-1:0] cnt;
    logic s1, s2, a_sgn, b_sgn, a_neg, b_neg, accept, quick, quick_err;
    logic [XLEN-1:0] a_mag, b_mag, quick_res, fix_res, mul_res;
    logic [XLEN:0] hi_sum;
    assign in_ready  = state == IDLE && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_comb begin
        a_sgn = in_funct3[2] ? !in_funct3[0] : (in_funct3[1] ^ in_funct3[0]);
        b_sgn = in_funct3[2] ? !in_funct3[0] : (in_funct3[1:0] == 2'b01);
        a_neg = a_sgn && in_op1[XLEN-1];
        b_neg = b_sgn && in_op2[XLEN-1];
        a_mag = a_neg ? -in_op1 : in_op1;
        b_mag = b_neg ? -in_op2 : in_op2;
`ifdef MULDIV_DIV_EN
        // zero divisor and signed overflow bypass the iteration entirely
        quick = in_funct3[2] && (in_op2 == '0 || (!in_funct3[0] && in_op1 == {1'b1, {(XLEN-1){1'b0}}} && &in_op2));
        quick_res = in_op2 == '0 ? (in_funct3[1] ? in_op1 : '1) : (in_funct3[1] ? '0 : in_op1);
        quick_err = 1'b0;
`else
        quick     = in_funct3[2];
        quick_res = '0;
        quick_err = 1'b1;
`endif
    end
    always_comb begin
        hi_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, b} : '0);
        prod_nx = {hi_sum, prod[XLEN-1:1]};
        p_fix   = (s1 ^ s2) ? -prod : prod;
        mul_res = f3[1:0] == 2'b00 ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
        fix_res = f3[2] ? '0 : mul_res;
`ifdef MULDIV_DIV_EN
        begin : div_path
            logic [XLEN:0] r_sh, r_sub;
            logic ge;
            logic [XLEN-1:0] q_fix, r_fix;
            // restoring step: remainder in the high half, dividend shifts out / quotient shifts in low
            r_sh  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
            r_sub = r_sh - {1'b0, b};
            ge    = r_sh >= {1'b0, b};
            if (f3[2]) prod_nx = {ge ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0], prod[XLEN-2:0], ge};
            q_fix = (s1 ^ s2) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
            r_fix = s1 ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
            fix_res = !f3[2] ? mul_res : f3[1] ? r_fix : q_fix;
        end
`endif
    end
    always_comb begin
        state_nx = flush ? IDLE
                 : state == IDLE ? (accept ? (quick ? DONE : CALC) : IDLE)
                 : state == CALC ? (cnt == '0 ? DONE : CALC)
                 : (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3         <= '0;
            b          <= '0;
            prod       <= '0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            cnt        <= '0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else if (accept) begin
            f3         <= in_funct3;
            b          <= b_mag;
            prod       <= {{XLEN{1'b0}}, a_mag};
            s1         <= a_neg;
            s2         <= b_neg;
            out_tag    <= in_tag;
            cnt        <= quick ? '0 : CW'(XLEN);
            out_result <= quick ? quick_res : '0;
            out_err    <= quick && quick_err;
        end else if (state == CALC && !flush) begin
            if (cnt != '0) begin
                prod <= prod_nx;
                cnt  <= cnt - 1'b1;
            end else begin
                out_result <= fix_res;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit (XLEN=32); divide vectors selected by MULDIV_DIV_EN
module tb_muldiv_unit;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_err, busy;
    logic [2:0] in_funct3 = '0;
    logic [31:0] in_op1 = '0, in_op2 = '0, out_result;
    logic [4:0] in_tag = '0, out_tag;
    int n_cmp = 0, n_bad = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
        end
    endtask

    task automatic run(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] bb,
                       input logic [4:0] t, input logic [31:0] er, input int el, input logic ee, input int hold);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = f; in_op1 = a; in_op2 = bb; in_tag = t;
        chk({nm, ".in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_funct3 = 3'($urandom); in_op1 = $urandom; in_op2 = $urandom; in_tag = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, ".latency"}, lat, el);
        chk({nm, ".result"}, out_result, er);
        chk({nm, ".tag"}, out_tag, t);
        chk({nm, ".err"}, out_err, ee);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, ".hold_valid"}, out_valid, 1);
            chk({nm, ".hold_result"}, out_result, er);
            chk({nm, ".hold_tag"}, out_tag, t);
            chk({nm, ".hold_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b1; in_funct3 = 3'b000;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk({nm, ".release_valid"}, out_valid, 0);
        chk({nm, ".release_busy"}, busy, 0);
    endtask

    initial begin
        #1;
        chk("rst.valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.result", out_result, 0);
        chk("rst.tag", out_tag, 0);
        chk("rst.err", out_err, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("rst.in_ready_after", in_ready, 1);

        run("mul", 3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 34, 1'b0, 0);
        run("mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 34, 1'b0, 0);
        run("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE, 34, 1'b0, 0);
        run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd6, 32'hFFFFFFFF, 34, 1'b0, 0);
        run("mul2", 3'b000, 32'h12345678, 32'h00000010, 5'd7, 32'h23456780, 34, 1'b0, 0);
        run("mulhu2", 3'b011, 32'h12345678, 32'h00000010, 5'd8, 32'h00000001, 34, 1'b0, 0);
        run("mulh_neg", 3'b001, 32'hFFFFFFFF, 32'h00000003, 5'd9, 32'hFFFFFFFF, 34, 1'b0, 0);
        run("mul_hold", 3'b000, 32'h00000009, 32'h00000006, 5'd31, 32'h00000036, 34, 1'b0, 10);
`ifdef MULDIV_DIV_EN
        run("div", 3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFD, 34, 1'b0, 0);
        run("rem", 3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFF, 34, 1'b0, 0);
        run("divu0", 3'b101, 32'h00000005, 32'h00000000, 5'd12, 32'hFFFFFFFF, 1, 1'b0, 0);
        run("remu0", 3'b111, 32'h00000005, 32'h00000000, 5'd13, 32'h00000005, 1, 1'b0, 0);
        run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1, 1'b0, 0);
        run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1, 1'b0, 0);
        run("divu", 3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 34, 1'b0, 0);
        run("remu", 3'b111, 32'd100, 32'd7, 5'd17, 32'd2, 34, 1'b0, 0);
        run("div0s", 3'b100, 32'h80000000, 32'h00000000, 5'd18, 32'hFFFFFFFF, 1, 1'b0, 0);
`else
        run("divu_off", 3'b101, 32'd9, 32'd3, 5'd10, 32'h00000000, 1, 1'b1, 0);
        run("rem_off", 3'b110, 32'd5, 32'd3, 5'd11, 32'h00000000, 1, 1'b1, 0);
`endif
        run("mul_after_err", 3'b000, 32'd3, 32'd5, 5'd20, 32'd15, 34, 1'b0, 0);

        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b000; in_op1 = 32'd11; in_op2 = 32'd13; in_tag = 5'd21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        #1 chk("flush.in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.valid", out_valid, 0);
        chk("flush.busy", busy, 0);
        repeat (40) @(posedge clk);
        #1 chk("flush.no_result", out_valid, 0);
        chk("flush.in_ready_after", in_ready, 1);

        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b011; in_op1 = 32'd11; in_op2 = 32'd13; in_tag = 5'd22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid.busy", busy, 0);
        chk("rst_mid.tag", out_tag, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("rst_mid.no_result", out_valid, 0);
        chk("rst_mid.in_ready", in_ready, 1);

        run("mul_final", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, 32'h00000001, 34, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width, even, >= 8.
REQ-002 Parameter TAG_W, default 5: width of the destination tag carried alongside each operation.
REQ-003 Port clk  in  1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port flush  in  1: abort any operation in progress.
REQ-006 Port in_valid  in  1: request present.
REQ-007 Port in_ready  out  1: unit accepts a request this cycle.
REQ-008 Port in_funct3  in  3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 Port in_op1  in  XLEN: rs1 value (multiplicand or dividend).
REQ-010 Port in_op2  in  XLEN: rs2 value (multiplier or divisor).
REQ-011 Port in_tag  in  TAG_W: destination tag.
REQ-012 Port out_valid  out  1: result present.
REQ-013 Port out_ready  in  1: consumer takes the result.
REQ-014 Port out_result  out  XLEN: result.
REQ-015 Port out_tag  out  TAG_W: tag of the accepted request.
REQ-016 Port out_err  out  1: unsupported operation; result forced to 0.
REQ-017 Port busy  out  1: high whenever the state is not IDLE.

Function
REQ-018 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-019 in_ready SHALL equal (state==IDLE) && !flush, and a request SHALL be accepted on an edge where in_valid && in_ready.
REQ-020 On acceptance the unit SHALL register funct3, the operands, the tag and the operand sign flags (MULH/DIV/REM: both signed; MULHSU: op1 only).
REQ-021 Normal accept SHALL go IDLE->CALC with a counter loaded to XLEN.
REQ-022 CALC SHALL process one bit per cycle: shift-add on operand magnitudes for multiply, restoring shift-subtract on magnitudes for divide.
REQ-023 CALC SHALL move to DONE on the edge where the counter reaches 0, so out_valid rises exactly XLEN+1 edges after the acceptance edge.
REQ-024 On CALC->DONE the sign correction SHALL be applied: the 2*XLEN product is negated if the operand signs differ; the quotient is negated if the signs differ; the remainder takes the dividend's sign.
REQ-025 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-026 A divisor of 0 SHALL go IDLE->DONE in 1 edge: DIV/DIVU return all ones, REM/REMU return op1.
REQ-027 Signed overflow (op1 = -2^(XLEN-1), op2 = -1) on DIV/REM SHALL go IDLE->DONE in 1 edge: DIV returns op1, REM returns 0.
REQ-028 In DONE, out_valid SHALL be 1 and out_result, out_tag and out_err SHALL be held stable until out_valid && out_ready.
REQ-029 DONE SHALL return to IDLE on out_valid && out_ready; no new request is accepted in that same cycle.
REQ-030 flush SHALL force IDLE on the next edge from any state and drop the result; out_valid is 0 after that edge.
REQ-031 out_valid SHALL be 0 in IDLE and CALC.
REQ-032 Operand inputs SHALL be ignored outside the acceptance edge.

Reset
REQ-033 rst_n low SHALL immediately set: state to IDLE, counter to 0, out_valid 0, out_result 0, out_tag 0, out_err 0, busy 0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation; no result is produced after release.
REQ-035 in_ready SHALL be 1 on the first cycle after release when flush is low.

Configuration
REQ-036 With macro MULDIV_DIV_EN defined, all eight funct3 operations SHALL be implemented as specified above.
REQ-037 Without MULDIV_DIV_EN, the divide datapath SHALL be absent; funct3[2]=1 SHALL go IDLE->DONE in 1 edge with out_result 0 and out_err 1.
REQ-038 out_err SHALL be 0 for every operation when MULDIV_DIV_EN is defined.

Verification (XLEN=32, MULDIV_DIV_EN defined unless stated)
REQ-039 MUL 7 x 0xFFFFFFFD, tag 3 -> out_valid 33 edges after accept, result 0xFFFFFFEB, tag 3.
REQ-040 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-041 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each after 1 edge.
REQ-042 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 edge; REM of the same operands -> 0.
REQ-043 out_ready held low for 10 cycles after out_valid -> result and tag stable, in_ready 0; flush 5 cycles after accept -> IDLE next edge, no out_valid.
REQ-044 MULDIV_DIV_EN undefined, DIVU 9 / 3 -> out_valid after 1 edge, result 0, out_err 1.
